uart_rx: RTL

Serial receiver for the UART path. Samples an asynchronous 8N1 line (8 data bits, no parity, 1 stop bit), deserialises one byte per frame, and presents it on `o_data` with a one-cycle `o_ready_to_read` strobe. It sits directly upstream of the byte-decode/LED stage, which registers `o_data`/`o_ready_to_read` and compares against fixed codes such as 8'h41 ('A'). Framing errors are flagged and the bad byte is never delivered.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state type, default bit timing and
// frame width. The transmitter will import this package as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200
    localparam int UART_DATA_BITS            = 8;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for an asynchronous input.
// Ports:
//   clk   - destination clock
//   rst   - asynchronous active-high reset, both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronised output (2 cycles latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second filters it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronises the raw line, finds the start bit on a
// high-to-low transition, samples every bit at mid-bit and delivers the byte
// with a one-cycle strobe. A low stop bit raises a framing-error strobe and
// the byte is dropped.
// Ports:
//   clk             - system clock
//   rst             - asynchronous active-high reset
//   i_rx            - raw serial line (idles high)
//   o_data          - last good byte, [0] is the MSB, first line bit in [7]
//   o_ready_to_read - one-cycle pulse when o_data takes a new byte
//   o_frame_err     - one-cycle pulse when the stop bit samples low
//   o_busy          - high whenever a frame is in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_rx,
    output logic [0:UART_DATA_BITS-1] o_data,
    output logic                      o_ready_to_read,
    output logic                      o_frame_err,
    output logic                      o_busy
);

    localparam int          HALF = CLKS_PER_BIT / 2;
    localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW   = $clog2(UART_DATA_BITS);

    logic                      rx_s;
    logic                      rx_prev;
    uart_rx_state_t            state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [0:UART_DATA_BITS-1] data_d;
    logic                      rdy_d;
    logic                      ferr_d;
    logic                      busy_d;
    logic                      bit_end;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            idx_q           <= '0;
            shift_q         <= '0;
            rx_prev         <= 1'b1;
            o_data          <= '0;
            o_ready_to_read <= 1'b0;
            o_frame_err     <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            idx_q           <= idx_d;
            shift_q         <= shift_d;
            rx_prev         <= rx_s;
            o_data          <= data_d;
            o_ready_to_read <= rdy_d;
            o_frame_err     <= ferr_d;
            o_busy          <= busy_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = o_data;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                // Edge, not level: a held-low line (break) must rise first.
                if (rx_prev && !rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (timer_q == TW'(HALF - 1)) begin
                    timer_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        rdy_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule : uart_rx
